// File: rtl/elevator_car_ctrl_if.sv
// rtl/elevator_car_ctrl_if.sv - call/status bundle between the call logic and the car controller
// master: req_set, default_floor, hold_door, estop out; car status in
// slave : car status out (current_floor, dir_up, moving, door_open,
//         served_valid, served_floor, pending); calls and controls in
interface elevator_car_ctrl_if #(
    parameter int NUM_FLOORS = 8
);
    localparam int FW = $clog2(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] req_set;
    logic [FW-1:0]         default_floor;
    logic                  hold_door;
    logic                  estop;
    logic [FW-1:0]         current_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic                  served_valid;
    logic [FW-1:0]         served_floor;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req_set, default_floor, hold_door, estop,
        input  current_floor, dir_up, moving, door_open,
               served_valid, served_floor, pending
    );

    modport slave (
        input  req_set, default_floor, hold_door, estop,
        output current_floor, dir_up, moving, door_open,
               served_valid, served_floor, pending
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - single-car LOOK elevator controller with tick, dwell, estop and parking
// clk, reset (async, active-high)
// bus (slave): req_set/default_floor/hold_door/estop in;
//              current_floor/dir_up/moving/door_open/served_valid/served_floor/pending out
module elevator_car_ctrl #(
    parameter int NUM_FLOORS   = 8,
    parameter int TICK_DIV     = 10,
    parameter int TRAVEL_TICKS = 1,
    parameter int DWELL_TICKS  = 2,
    parameter int PARK_TICKS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    elevator_car_ctrl_if.slave  bus
);
    localparam int FW = $clog2(NUM_FLOORS);
    localparam int DW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int CW = $clog2(DWELL_TICKS + 1);
    localparam int PW = $clog2(PARK_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_ESTOP} state_t;

    state_t                state;
    logic [DW-1:0]         div_cnt;
    logic [TW-1:0]         trav_cnt;
    logic [CW-1:0]         dwell_cnt;
    logic [PW-1:0]         park_cnt;
    logic                  park_mode;
    logic [FW-1:0]         cur_floor;
    logic                  dir_up_r;
    logic                  moving_r;
    logic                  door_r;
    logic                  served_v;
    logic [FW-1:0]         served_f;
    logic [NUM_FLOORS-1:0] pending_r;

    logic                  tick;
    logic [FW-1:0]         nxt;
    logic                  step;
    logic                  door_go;
    logic [FW-1:0]         door_floor;
    logic [NUM_FLOORS-1:0] clr;
    logic                  up_look;
    logic                  ahead;
    logic                  park_ok;

    function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && (i > int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && (i < int'(f))) r = 1'b1;
        return r;
    endfunction

    always_comb begin
        tick    = (div_cnt == DW'(TICK_DIV - 1));
        nxt     = dir_up_r ? cur_floor + FW'(1) : cur_floor - FW'(1);
        step    = (state == S_MOVE) && tick && (trav_cnt == TW'(TRAVEL_TICKS - 1));
        up_look = calls_above(pending_r, cur_floor) &&
                  (dir_up_r || !calls_below(pending_r, cur_floor));
        ahead   = dir_up_r ? calls_above(pending_r, nxt) : calls_below(pending_r, nxt);
        park_ok = int'(bus.default_floor) < NUM_FLOORS;

        // Door entry is decided here so the pending clear lands in the same
        // cycle as the transition, on the floor the door opens at.
        door_go    = 1'b0;
        door_floor = cur_floor;
        if (!bus.estop) begin
            if (state == S_IDLE && pending_r[cur_floor]) begin
                door_go = 1'b1;
            end else if (step && pending_r[nxt]) begin
                door_go    = 1'b1;
                door_floor = nxt;
            end
        end

        clr = '0;
        if (state == S_DOOR) clr[cur_floor] = 1'b1;
        if (door_go) clr[door_floor] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            trav_cnt  <= '0;
            dwell_cnt <= '0;
            park_cnt  <= '0;
            park_mode <= 1'b0;
            cur_floor <= '0;
            dir_up_r  <= 1'b1;
            moving_r  <= 1'b0;
            door_r    <= 1'b0;
            served_v  <= 1'b0;
            served_f  <= '0;
            pending_r <= '0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + DW'(1);
            pending_r <= (pending_r | bus.req_set) & ~clr;
            served_v  <= 1'b0;

            if (bus.estop) begin
                state     <= S_ESTOP;
                moving_r  <= 1'b0;
                door_r    <= 1'b0;
                trav_cnt  <= '0;
                dwell_cnt <= '0;
                park_cnt  <= '0;
                park_mode <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (door_go) begin
                            state     <= S_DOOR;
                            door_r    <= 1'b1;
                            served_v  <= 1'b1;
                            served_f  <= cur_floor;
                            dwell_cnt <= '0;
                            park_cnt  <= '0;
                        end else if (pending_r != '0) begin
                            park_cnt <= '0;
                            if (tick) begin
                                state     <= S_MOVE;
                                moving_r  <= 1'b1;
                                trav_cnt  <= '0;
                                dir_up_r  <= up_look;
                                park_mode <= 1'b0;
                            end
                        end else if (park_cnt == PW'(PARK_TICKS)) begin
                            if (park_ok && cur_floor != bus.default_floor) begin
                                state     <= S_MOVE;
                                moving_r  <= 1'b1;
                                trav_cnt  <= '0;
                                dir_up_r  <= bus.default_floor > cur_floor;
                                park_mode <= 1'b1;
                                park_cnt  <= '0;
                            end
                        end else if (tick) begin
                            park_cnt <= park_cnt + PW'(1);
                        end
                    end

                    S_MOVE: begin
                        if (pending_r != '0) park_mode <= 1'b0;
                        if (tick) begin
                            if (step) begin
                                trav_cnt  <= '0;
                                cur_floor <= nxt;
                                // End floors pin the direction; the branches below may override.
                                if (nxt == FW'(NUM_FLOORS - 1)) dir_up_r <= 1'b0;
                                else if (nxt == '0)             dir_up_r <= 1'b1;
                                if (door_go) begin
                                    state     <= S_DOOR;
                                    moving_r  <= 1'b0;
                                    door_r    <= 1'b1;
                                    served_v  <= 1'b1;
                                    served_f  <= nxt;
                                    dwell_cnt <= '0;
                                end else if (park_mode && pending_r == '0 && nxt == bus.default_floor) begin
                                    state     <= S_IDLE;
                                    moving_r  <= 1'b0;
                                    park_mode <= 1'b0;
                                end else if (!ahead && pending_r != '0) begin
                                    dir_up_r <= !dir_up_r;
                                end else if (pending_r == '0 && !park_mode) begin
                                    state    <= S_IDLE;
                                    moving_r <= 1'b0;
                                end
                            end else begin
                                trav_cnt <= trav_cnt + TW'(1);
                            end
                        end
                    end

                    S_DOOR: begin
                        if (tick) begin
                            if (dwell_cnt == CW'(DWELL_TICKS - 1)) begin
                                dwell_cnt <= '0;
                                if (!bus.hold_door) begin
                                    state  <= S_IDLE;
                                    door_r <= 1'b0;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt + CW'(1);
                            end
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.current_floor = cur_floor;
    assign bus.dir_up        = dir_up_r;
    assign bus.moving        = moving_r;
    assign bus.door_open     = door_r;
    assign bus.served_valid  = served_v;
    assign bus.served_floor  = served_f;
    assign bus.pending       = pending_r;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - scoreboard bench for elevator_car_ctrl
module tb_elevator_car_ctrl;
    localparam int NF1 = 8;
    localparam int NF2 = 6;

    logic clk;
    logic reset;

    elevator_car_ctrl_if #(.NUM_FLOORS(NF1)) bus ();
    elevator_car_ctrl_if #(.NUM_FLOORS(NF2)) bus2 ();

    elevator_car_ctrl #(
        .NUM_FLOORS(NF1), .TICK_DIV(4), .TRAVEL_TICKS(2), .DWELL_TICKS(3), .PARK_TICKS(5)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    elevator_car_ctrl #(
        .NUM_FLOORS(NF2), .TICK_DIV(4), .TRAVEL_TICKS(2), .DWELL_TICKS(3), .PARK_TICKS(5)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int n_cmp;
    int n_fail;
    logic [7:0] sb[$];
    logic door_seen;
    logic moving2_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_moving(input string tag, input logic val, input int limit);
        int k = 0;
        while (bus.moving !== val && k < limit) begin cyc(); k++; end
        check(tag, bus.moving, val);
    endtask

    task automatic wait_door(input string tag, input logic val, input int limit);
        int k = 0;
        while (bus.door_open !== val && k < limit) begin cyc(); k++; end
        check(tag, bus.door_open, val);
    endtask

    task automatic wait_floor(input string tag, input logic [2:0] f, input int limit);
        int k = 0;
        while (bus.current_floor !== f && k < limit) begin cyc(); k++; end
        check(tag, bus.current_floor, f);
    endtask

    task automatic wait_sb(input string tag, input int n, input int limit);
        int k = 0;
        while (sb.size() != n && k < limit) begin cyc(); k++; end
        check(tag, sb.size(), n);
    endtask

    // Served-floor scoreboard, floor range and activity flags.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!reset) begin
            check("cf_range", logic'(int'(bus.current_floor) < NF1), 1'b1);
            check("cf2_range", logic'(int'(bus2.current_floor) < NF2), 1'b1);
            if (bus.door_open) door_seen = 1'b1;
            if (bus2.moving) moving2_seen = 1'b1;
            if (bus.served_valid) begin
                check("served_expected", logic'(sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("served_floor", bus.served_floor, exp);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        door_seen = 1'b0;
        moving2_seen = 1'b0;
        reset = 1'b1;
        bus.req_set = '0;
        bus.default_floor = 3'd7;
        bus.hold_door = 1'b0;
        bus.estop = 1'b0;
        bus2.req_set = '0;
        bus2.default_floor = 3'd7;
        bus2.hold_door = 1'b0;
        bus2.estop = 1'b0;

        // Reset values
        repeat (2) cyc();
        check("rst_floor", bus.current_floor, 0);
        check("rst_dir", bus.dir_up, 1);
        check("rst_moving", bus.moving, 0);
        check("rst_door", bus.door_open, 0);
        check("rst_served", bus.served_valid, 0);
        check("rst_pending", bus.pending, 0);

        // Single call to floor 5 with exact timing
        reset = 1'b0;
        bus.req_set = 8'h20;
        sb.push_back(8'd5);
        cyc();
        bus.req_set = '0;
        check("single_pending", bus.pending, 8'h20);
        repeat (2) cyc();
        check("single_not_departed", bus.moving, 0);
        cyc();
        check("single_departed", bus.moving, 1);
        repeat (7) cyc();
        check("single_floor0", bus.current_floor, 0);
        cyc();
        check("single_floor1", bus.current_floor, 1);
        repeat (32) cyc();
        check("single_served", bus.served_valid, 1);
        check("single_door", bus.door_open, 1);
        check("single_at5", bus.current_floor, 5);
        check("single_cleared", bus.pending, 0);
        repeat (11) cyc();
        check("single_door_last", bus.door_open, 1);
        bus.req_set = 8'h20;
        cyc();
        bus.req_set = '0;
        check("single_door_closed", bus.door_open, 0);
        check("exit_call_absorbed", bus.pending, 0);

        // Park to floor 2 from floor 5
        bus.default_floor = 3'd2;
        door_seen = 1'b0;
        wait_moving("park_depart", 1, 60);
        check("park_dir_down", bus.dir_up, 0);
        wait_moving("park_stop", 0, 60);
        check("park_floor", bus.current_floor, 2);
        check("park_no_door", door_seen, 0);

        // Call at current floor, absorb while open, door hold
        sb.push_back(8'd2);
        bus.req_set = 8'h04;
        cyc();
        bus.req_set = '0;
        check("here_pending", bus.pending, 8'h04);
        cyc();
        check("here_door", bus.door_open, 1);
        check("here_floor", bus.current_floor, 2);
        bus.hold_door = 1'b1;
        bus.req_set = 8'h04;
        cyc();
        bus.req_set = '0;
        check("here_absorbed", bus.pending, 0);
        repeat (30) cyc();
        check("hold_open", bus.door_open, 1);
        bus.hold_door = 1'b0;
        wait_door("hold_release_close", 0, 14);
        check("hold_pending", bus.pending, 0);

        // Emergency stop between floors 2 and 3
        sb.push_back(8'd5);
        sb.push_back(8'd0);
        bus.req_set = 8'h20;
        cyc();
        bus.req_set = '0;
        wait_moving("estop_depart", 1, 10);
        repeat (4) cyc();
        check("estop_pre_floor", bus.current_floor, 2);
        bus.estop = 1'b1;
        cyc();
        check("estop_stopped", bus.moving, 0);
        bus.req_set = 8'h01;
        cyc();
        bus.req_set = '0;
        check("estop_pending", bus.pending, 8'h21);
        repeat (20) cyc();
        check("estop_frozen", bus.current_floor, 2);
        check("estop_still", bus.moving, 0);
        bus.estop = 1'b0;
        wait_sb("estop_resume", 0, 300);
        check("estop_end_floor", bus.current_floor, 0);

        // Reset mid-operation
        bus.req_set = 8'h80;
        cyc();
        bus.req_set = '0;
        wait_moving("midrst_depart", 1, 30);
        reset = 1'b1;
        #1;
        check("midrst_floor", bus.current_floor, 0);
        check("midrst_moving", bus.moving, 0);
        check("midrst_pending", bus.pending, 0);
        check("midrst_dir", bus.dir_up, 1);
        cyc();
        reset = 1'b0;

        // LOOK order 4, 6, 1
        bus.default_floor = 3'd7;
        bus.req_set = 8'h40;
        cyc();
        bus.req_set = '0;
        wait_floor("look_at3", 3'd3, 60);
        check("look_moving_at3", bus.moving, 1);
        bus.req_set = 8'h12;
        sb.push_back(8'd4);
        sb.push_back(8'd6);
        sb.push_back(8'd1);
        cyc();
        bus.req_set = '0;
        wait_sb("look_two_served", 1, 200);
        wait_moving("look_depart6", 1, 30);
        check("look_dir_down", bus.dir_up, 0);
        wait_sb("look_all_served", 0, 200);
        check("look_end_floor", bus.current_floor, 1);

        // Parking disabled on a 6-floor car with default_floor=7
        check("nopark_idle", moving2_seen, 0);
        bus2.req_set = 6'b001000;
        cyc();
        bus2.req_set = '0;
        begin
            int k = 0;
            while (bus2.served_valid !== 1'b1 && k < 80) begin cyc(); k++; end
            check("nopark_served", bus2.served_valid, 1);
            check("nopark_served_floor", bus2.served_floor, 3);
            k = 0;
            while (bus2.door_open !== 1'b0 && k < 20) begin cyc(); k++; end
            check("nopark_door_closed", bus2.door_open, 0);
        end
        moving2_seen = 1'b0;
        repeat (150) cyc();
        check("nopark_no_move", moving2_seen, 0);
        check("nopark_floor", bus2.current_floor, 3);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
